// File: rtl/r_resp_router.sv
// rtl/r_resp_router.sv - read-data return router: slave R beats to M0/M1 by master tag
module r_resp_router #(
   parameter int ID_BITS   = 4,
   parameter int DATA_BITS = 32
) (
   input  logic                 ACLK,
   input  logic                 ARESETn,
   input  logic [ID_BITS+3:0]   RID_S,
   input  logic [DATA_BITS-1:0] RDATA_S,
   input  logic [1:0]           RRESP_S,
   input  logic                 RLAST_S,
   input  logic                 RVALID_S,
   output logic                 RREADY_S,
   output logic [ID_BITS-1:0]   RID_M0,
   output logic [DATA_BITS-1:0] RDATA_M0,
   output logic [1:0]           RRESP_M0,
   output logic                 RLAST_M0,
   output logic                 RVALID_M0,
   input  logic                 RREADY_M0,
   output logic [ID_BITS-1:0]   RID_M1,
   output logic [DATA_BITS-1:0] RDATA_M1,
   output logic [1:0]           RRESP_M1,
   output logic                 RLAST_M1,
   output logic                 RVALID_M1,
   input  logic                 RREADY_M1,
   output logic [7:0]           beat_cnt,
   output logic                 err_tag
);

   localparam int IW = ID_BITS + 4;

   typedef enum logic [1:0] {IDLE, BURST_M0, BURST_M1, DROP} routeStateT;

   routeStateT state, stateNext;

   logic [IW-1:0]        bufId   [2];
   logic [DATA_BITS-1:0] bufData [2];
   logic [1:0]           bufResp [2];
   logic                 bufLast [2];
   logic                 wrPtr, rdPtr;
   logic [1:0]           count, countNext;

   logic                 headValid, headLast;
   logic [IW-1:0]        headId;
   logic [3:0]           headTag;
   logic                 push, pop, toM0, toM1, dropNow, errNow;

   logic [ID_BITS-1:0]   holdId0, holdId1;
   logic [DATA_BITS-1:0] holdData0, holdData1;
   logic [1:0]           holdResp0, holdResp1;
   logic                 holdLast0, holdLast1;

   assign headValid = (count != 2'd0);
   assign headId    = bufId[rdPtr];
   assign headLast  = bufLast[rdPtr];
   assign headTag   = headId[IW-1:ID_BITS];
   assign push      = RVALID_S & RREADY_S;

   // Routing decision for the head beat, pop condition and burst-lock transitions
   always_comb begin
      stateNext = state;
      toM0      = 1'b0;
      toM1      = 1'b0;
      dropNow   = 1'b0;
      errNow    = 1'b0;
      case (state)
         IDLE: begin
            if (headValid) begin
               if (headTag == 4'd0) begin
                  toM0 = 1'b1;
               end else if (headTag == 4'd1) begin
                  toM1 = 1'b1;
               end else begin
                  dropNow = 1'b1;
                  errNow  = 1'b1;
               end
            end
         end
         BURST_M0: begin
            toM0   = headValid;
            errNow = (headTag != 4'd0);
         end
         BURST_M1: begin
            toM1   = headValid;
            errNow = (headTag != 4'd1);
         end
         DROP: begin
            dropNow = headValid;
         end
         default: ;
      endcase
      pop = (toM0 & RREADY_M0) | (toM1 & RREADY_M1) | dropNow;
      if (pop) begin
         if (headLast) begin
            stateNext = IDLE;
         end else if (state == IDLE) begin
            stateNext = toM0 ? BURST_M0 : (toM1 ? BURST_M1 : DROP);
         end
      end
   end

   // Occupancy after this cycle's push/pop; drives the registered slave ready
   always_comb begin
      countNext = count;
      case ({push, pop})
         2'b10:   countNext = count + 2'd1;
         2'b01:   countNext = count - 2'd1;
         default: countNext = count;
      endcase
   end

   // Routing FSM state register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state <= IDLE;
      else          state <= stateNext;
   end

   // Two-entry skid buffer storage, pointers and slave-side ready
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         for (int i = 0; i < 2; i++) begin
            bufId[i]   <= '0;
            bufData[i] <= '0;
            bufResp[i] <= '0;
            bufLast[i] <= 1'b0;
         end
         wrPtr    <= 1'b0;
         rdPtr    <= 1'b0;
         count    <= 2'd0;
         RREADY_S <= 1'b0;
      end else begin
         if (push) begin
            bufId[wrPtr]   <= RID_S;
            bufData[wrPtr] <= RDATA_S;
            bufResp[wrPtr] <= RRESP_S;
            bufLast[wrPtr] <= RLAST_S;
            wrPtr          <= ~wrPtr;
         end
         if (pop) rdPtr <= ~rdPtr;
         count    <= countNext;
         RREADY_S <= (countNext != 2'd2);
      end
   end

   // Per-burst beat counter (saturating) and one-cycle tag error pulse
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         beat_cnt <= 8'd0;
         err_tag  <= 1'b0;
      end else begin
         err_tag <= pop & errNow;
         if (pop) begin
            if (headLast)               beat_cnt <= 8'd0;
            else if (beat_cnt != 8'hFF) beat_cnt <= beat_cnt + 8'd1;
         end
      end
   end

   // Last beat accepted by each master, shown while that master is not selected
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         holdId0   <= '0;
         holdData0 <= '0;
         holdResp0 <= '0;
         holdLast0 <= 1'b0;
         holdId1   <= '0;
         holdData1 <= '0;
         holdResp1 <= '0;
         holdLast1 <= 1'b0;
      end else begin
         if (toM0 & RREADY_M0) begin
            holdId0   <= headId[ID_BITS-1:0];
            holdData0 <= bufData[rdPtr];
            holdResp0 <= bufResp[rdPtr];
            holdLast0 <= headLast;
         end
         if (toM1 & RREADY_M1) begin
            holdId1   <= headId[ID_BITS-1:0];
            holdData1 <= bufData[rdPtr];
            holdResp1 <= bufResp[rdPtr];
            holdLast1 <= headLast;
         end
      end
   end

   assign RVALID_M0 = toM0;
   assign RID_M0    = toM0 ? headId[ID_BITS-1:0] : holdId0;
   assign RDATA_M0  = toM0 ? bufData[rdPtr]      : holdData0;
   assign RRESP_M0  = toM0 ? bufResp[rdPtr]      : holdResp0;
   assign RLAST_M0  = toM0 ? headLast            : holdLast0;

   assign RVALID_M1 = toM1;
   assign RID_M1    = toM1 ? headId[ID_BITS-1:0] : holdId1;
   assign RDATA_M1  = toM1 ? bufData[rdPtr]      : holdData1;
   assign RRESP_M1  = toM1 ? bufResp[rdPtr]      : holdResp1;
   assign RLAST_M1  = toM1 ? headLast            : holdLast1;

endmodule

// File: tb/tb_r_resp_router.sv
// tb/tb_r_resp_router.sv - self-checking bench for r_resp_router
module tb_r_resp_router;

   typedef logic [38:0] beatT;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   logic [7:0]  RID_S = '0;
   logic [31:0] RDATA_S = '0;
   logic [1:0]  RRESP_S = '0;
   logic        RLAST_S = 1'b0;
   logic        RVALID_S = 1'b0;
   logic        RREADY_S;
   logic [3:0]  RID_M0, RID_M1;
   logic [31:0] RDATA_M0, RDATA_M1;
   logic [1:0]  RRESP_M0, RRESP_M1;
   logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1;
   logic        RREADY_M0 = 1'b0;
   logic        RREADY_M1 = 1'b0;
   logic [7:0]  beat_cnt;
   logic        err_tag;

   int   errors = 0;
   int   checks = 0;
   int   errSeen = 0;
   int   bothValid = 0;
   int   expErr = 0;
   int   cmp0 = 0;
   int   cmp1 = 0;
   bit   rndReady = 1'b0;
   beatT exp0[$], exp1[$], got0[$], got1[$];

   r_resp_router #(.ID_BITS(4), .DATA_BITS(32)) dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
      .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
      .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
      .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
      .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
      .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
      .beat_cnt(beat_cnt), .err_tag(err_tag)
   );

   always #5 ACLK = ~ACLK;

   // Record master handshakes, error pulses and illegal dual-valid on the falling edge
   always @(negedge ACLK) begin
      if (RVALID_M0 && RREADY_M0) got0.push_back({RID_M0, RDATA_M0, RRESP_M0, RLAST_M0});
      if (RVALID_M1 && RREADY_M1) got1.push_back({RID_M1, RDATA_M1, RRESP_M1, RLAST_M1});
      if (err_tag) errSeen++;
      if (RVALID_M0 && RVALID_M1) bothValid++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
      if (rndReady) begin
         RREADY_M0 = 1'($urandom);
         RREADY_M1 = 1'($urandom);
      end
   endtask

   task automatic sendBeat(input logic [7:0] id, input logic [31:0] data,
                           input logic [1:0] resp, input logic last);
      int w;
      RID_S = id; RDATA_S = data; RRESP_S = resp; RLAST_S = last; RVALID_S = 1'b1;
      w = 0;
      while (!RREADY_S && w < 100) begin
         tick();
         w++;
      end
      if (!RREADY_S) check("send_timeout", 64'(RREADY_S), 64'(1));
      tick();
      RVALID_S = 1'b0;
   endtask

   // Burst-level reference: tag 0/1 lock the whole burst to that master, any other tag drops it
   task automatic sendBurst(input logic [3:0] tag, input int n, input int mmIdx, input logic [3:0] mmTag);
      for (int b = 0; b < n; b++) begin
         logic [3:0]  t;
         logic [3:0]  idl;
         logic [31:0] d;
         logic [1:0]  r;
         logic        last;
         t    = (b == mmIdx) ? mmTag : tag;
         idl  = 4'($urandom);
         d    = $urandom;
         r    = 2'($urandom);
         last = (b == n - 1);
         if (tag == 4'd0 || tag == 4'd1) begin
            if (tag == 4'd0) exp0.push_back({idl, d, r, last});
            else             exp1.push_back({idl, d, r, last});
            if (t != tag) expErr++;
         end else if (b == 0) begin
            expErr++;
         end
         sendBeat({t, idl}, d, r, last);
      end
   endtask

   task automatic drain(input string tag);
      int w;
      w = 0;
      while ((got0.size() < exp0.size() || got1.size() < exp1.size()) && w < 400) begin
         tick();
         w++;
      end
      repeat (4) tick();
      check({tag, "_m0_count"}, 64'(got0.size()), 64'(exp0.size()));
      check({tag, "_m1_count"}, 64'(got1.size()), 64'(exp1.size()));
      while (cmp0 < exp0.size() && cmp0 < got0.size()) begin
         check({tag, "_m0_beat"}, 64'(got0[cmp0]), 64'(exp0[cmp0]));
         cmp0++;
      end
      while (cmp1 < exp1.size() && cmp1 < got1.size()) begin
         check({tag, "_m1_beat"}, 64'(got1[cmp1]), 64'(exp1[cmp1]));
         cmp1++;
      end
      check({tag, "_err_pulses"}, 64'(errSeen), 64'(expErr));
      check({tag, "_beat_cnt_idle"}, 64'(beat_cnt), 64'(0));
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      check("rst_rready_s", 64'(RREADY_S), 64'(0));
      check("rst_rvalid_m0", 64'(RVALID_M0), 64'(0));
      check("rst_rvalid_m1", 64'(RVALID_M1), 64'(0));
      check("rst_beat_cnt", 64'(beat_cnt), 64'(0));
      check("rst_err_tag", 64'(err_tag), 64'(0));
      check("rst_rdata_m0", 64'(RDATA_M0), 64'(0));
      check("rst_rid_m1", 64'(RID_M1), 64'(0));
      ARESETn = 1'b1;
      check("rel_rready_s_low", 64'(RREADY_S), 64'(0));
      tick();
      check("rel_rready_s_high", 64'(RREADY_S), 64'(1));

      // Single beat to M0
      RREADY_M0 = 1'b1;
      RID_S = 8'h03; RDATA_S = 32'hDEADBEEF; RRESP_S = 2'b00; RLAST_S = 1'b1; RVALID_S = 1'b1;
      exp0.push_back({4'h3, 32'hDEADBEEF, 2'b00, 1'b1});
      tick();
      RVALID_S = 1'b0;
      check("single_rvalid_m0", 64'(RVALID_M0), 64'(1));
      check("single_rid_m0", 64'(RID_M0), 64'(3));
      check("single_rdata_m0", 64'(RDATA_M0), 64'(32'hDEADBEEF));
      check("single_rlast_m0", 64'(RLAST_M0), 64'(1));
      check("single_rvalid_m1", 64'(RVALID_M1), 64'(0));
      tick();
      check("single_after_rvalid_m0", 64'(RVALID_M0), 64'(0));
      check("single_after_beat_cnt", 64'(beat_cnt), 64'(0));

      // Back-to-back 4-beat burst to M1
      RREADY_M0 = 1'b0;
      RREADY_M1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         RID_S = 8'h12; RDATA_S = 32'(i + 1); RRESP_S = 2'b00; RLAST_S = (i == 3); RVALID_S = 1'b1;
         exp1.push_back({4'h2, 32'(i + 1), 2'b00, (i == 3)});
         tick();
         check("thru_rready_s", 64'(RREADY_S), 64'(1));
         check("thru_rvalid_m1", 64'(RVALID_M1), 64'(1));
         check("thru_rid_m1", 64'(RID_M1), 64'(2));
         check("thru_rdata_m1", 64'(RDATA_M1), 64'(i + 1));
         check("thru_rlast_m1", 64'(RLAST_M1), 64'(i == 3));
         check("thru_beat_cnt", 64'(beat_cnt), 64'(i));
      end
      RVALID_S = 1'b0;
      tick();
      check("thru_end_beat_cnt", 64'(beat_cnt), 64'(0));
      check("thru_end_rvalid_m1", 64'(RVALID_M1), 64'(0));
      drain("thru");

      // Backpressure on M0
      RREADY_M0 = 1'b0;
      for (int i = 0; i < 4; i++) exp0.push_back({4'h5, 32'hA0 + 32'(i), 2'b01, (i == 3)});
      RID_S = 8'h05; RDATA_S = 32'hA0; RRESP_S = 2'b01; RLAST_S = 1'b0; RVALID_S = 1'b1;
      tick();
      RDATA_S = 32'hA1;
      tick();
      check("bp_rready_s_low", 64'(RREADY_S), 64'(0));
      check("bp_rvalid_m0", 64'(RVALID_M0), 64'(1));
      check("bp_rdata_m0", 64'(RDATA_M0), 64'(32'hA0));
      RDATA_S = 32'hA2;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("bp_hold_rready_s", 64'(RREADY_S), 64'(0));
         check("bp_hold_rdata_m0", 64'(RDATA_M0), 64'(32'hA0));
         check("bp_hold_rid_m0", 64'(RID_M0), 64'(5));
      end
      RREADY_M0 = 1'b1;
      sendBeat(8'h05, 32'hA2, 2'b01, 1'b0);
      sendBeat(8'h05, 32'hA3, 2'b01, 1'b1);
      drain("bp");

      // Unknown tag burst dropped, then a normal burst to M0
      RREADY_M1 = 1'b1;
      sendBurst(4'd5, 2, -1, 4'd0);
      drain("unk");
      sendBurst(4'd0, 2, -1, 4'd0);
      drain("unk_next");

      // Mid-burst tag mismatch on beat 2
      sendBurst(4'd0, 3, 1, 4'd1);
      drain("mismatch");

      // Long dropped burst: beat counter saturates
      for (int i = 0; i < 257; i++) sendBeat(8'h70, 32'(i), 2'b00, 1'b0);
      expErr++;
      repeat (3) tick();
      check("sat_beat_cnt", 64'(beat_cnt), 64'(255));
      sendBeat(8'h70, 32'h0, 2'b00, 1'b1);
      drain("sat");

      // Reset in the middle of a stalled burst
      RREADY_M0 = 1'b0;
      RREADY_M1 = 1'b0;
      sendBeat(8'h01, 32'h11, 2'b00, 1'b0);
      RID_S = 8'h01; RDATA_S = 32'h22; RLAST_S = 1'b0; RVALID_S = 1'b1;
      #2;
      check("pre_rst_rvalid_m0", 64'(RVALID_M0), 64'(1));
      ARESETn = 1'b0;
      #1;
      check("mid_rst_rvalid_m0", 64'(RVALID_M0), 64'(0));
      check("mid_rst_rvalid_m1", 64'(RVALID_M1), 64'(0));
      check("mid_rst_rready_s", 64'(RREADY_S), 64'(0));
      check("mid_rst_beat_cnt", 64'(beat_cnt), 64'(0));
      RVALID_S = 1'b0;
      tick();
      ARESETn = 1'b1;
      tick();
      check("post_rst_rready_s", 64'(RREADY_S), 64'(1));
      RREADY_M1 = 1'b1;
      sendBurst(4'd1, 3, -1, 4'd0);
      drain("post_rst");

      // Randomized bursts with random master backpressure
      rndReady = 1'b1;
      for (int j = 0; j < 40; j++) begin
         int         r;
         int         n;
         int         mm;
         logic [3:0] tg;
         r  = int'($urandom_range(0, 9));
         tg = (r < 4) ? 4'd0 : (r < 8) ? 4'd1 : 4'($urandom_range(2, 15));
         n  = int'($urandom_range(1, 6));
         mm = (n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n - 1)) : -1;
         sendBurst(tg, n, mm, 4'($urandom));
         if (j % 10 == 9) drain("rnd");
      end
      check("never_both_valid", 64'(bothValid), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
